// File: rtl/xor_fold_pkg.sv
// Shared types and helpers for the round-robin XOR-fold scheduler.
package xor_fold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned W_DEF     = 8;
    localparam int unsigned IDW_DEF   = 2;
    localparam int unsigned CW_DEF    = 8;

    // Increment that sticks at the all-ones value of a cw-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned cw);
        logic [32:0] maxv;
        maxv = (33'd1 << cw) - 33'd1;
        return (33'(v) >= maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xor_fold_sched_rr_pick.sv
// Combinational round-robin selector: first set bit strictly after last_grant, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDW-1:0]   last_grant,
    output logic             any,
    output logic [IDW-1:0]   grant_id
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int unsigned        off;
    int unsigned        sum;

    // Rotate so bit 0 is the requester just after last_grant, then find the lowest set bit.
    always_comb begin
        dbl = {valid, valid};
        rot = N_REQ'(dbl >> (32'(last_grant) + 32'd1));
        off = 0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if ((rot & (N_REQ'(1) << i)) != '0) begin
                off = 32'(i);
            end
        end
        sum = 32'(last_grant) + 32'd1 + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        any      = |valid;
        grant_id = IDW'(sum);
    end

endmodule

// File: rtl/xor_fold_sched.sv
// Time-shares one XOR accumulator between requesters; folds one granted burst at a time
// and returns parity, id and saturating word count over a valid/ready result port.
module xor_fold_sched
    import xor_fold_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned IDW   = IDW_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_data,
    output logic [IDW-1:0]     res_id,
    output logic [CW-1:0]      res_count,
    output logic               busy
);

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last_grant;
    logic [W-1:0]   acc;
    logic [CW-1:0]  count;

    logic           pick_any;
    logic [IDW-1:0] pick_id;
    logic [W-1:0]   word_c;
    logic           take_c;
    logic           last_c;
    logic [W-1:0]   acc_next_c;
    logic [CW-1:0]  count_next_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .grant_id   (pick_id)
    );

    // req_ready is one-hot on the grant, so masking with it selects the granted lane.
    always_comb begin
        word_c       = W'(req_data >> (32'(grant) * W));
        take_c       = |(req_valid & req_ready);
        last_c       = |(req_last & req_ready);
        acc_next_c   = acc ^ word_c;
        count_next_c = CW'(sat_inc(32'(count), CW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(N_REQ - 1);
            acc        <= '0;
            count      <= '0;
            req_ready  <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            res_count  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant     <= pick_id;
                        acc       <= '0;
                        count     <= '0;
                        req_ready <= N_REQ'(1) << pick_id;
                        busy      <= 1'b1;
                        state     <= FOLD;
                    end
                end
                FOLD: begin
                    if (take_c) begin
                        acc   <= acc_next_c;
                        count <= count_next_c;
                        if (last_c) begin
                            req_ready <= '0;
                            res_valid <= 1'b1;
                            res_data  <= acc_next_c;
                            res_id    <= grant;
                            res_count <= count_next_c;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        busy       <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xor_fold_sched.md
Name: xor_fold_sched

Overview:
- Time-shares one W-bit XOR datapath (accumulator XOR incoming word) between N_REQ requesters.
- Each requester submits a burst of words. The block grants one requester at a time, round-robin, and XOR-folds its burst into an accumulator.
- It returns the folded parity word with the requester id and word count over a valid/ready result port.
- It sits between parity/checksum clients and the shared gate-level XOR logic.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- W, 8, operand/result width in bits
- IDW, 2, requester id width; must satisfy 2**IDW >= N_REQ
- CW, 8, word-count width; the count saturates

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  bit i: requester i presents a word
- req_data  input  N_REQ*W  requester i word at [i*W +: W]
- req_last  input  N_REQ  bit i: current word is the last of the burst
- req_ready  output  N_REQ  one-hot accept to the granted requester
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  W  XOR of all words in the burst
- res_id  output  IDW  index of the requester served
- res_count  output  CW  words folded, saturating at 2**CW-1
- busy  output  1  high in FOLD or RESP

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - state=IDLE.
  - req_ready, res_valid, res_data, res_id, res_count, busy all 0.
  - Accumulator 0, count 0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has top priority first.
- FSM states IDLE, FOLD, RESP:
  - IDLE, when any req_valid is set:
    - Pick the first set bit searching from last_grant+1 upward, wrapping.
    - Register grant id; clear acc and count; go to FOLD.
    - No word is consumed in the arbitration cycle.
  - FOLD:
    - req_ready[grant]=1, all other bits 0.
    - On req_valid[grant]&&req_ready[grant]: acc<=acc^word; count<=count+1, saturating.
    - If req_last[grant] is set on that accepted word, go to RESP.
  - RESP:
    - res_valid=1; res_data=acc, res_id=grant, res_count=count, all registered.
    - On res_ready: go to IDLE and set last_grant=grant.
- Latency: single-word burst accepted at the first FOLD cycle → res_valid 2 cycles after req_valid first seen in IDLE. Minimum of 3 cycles per single-word burst with res_ready held high.
- Bubbles: if the granted requester drops valid mid-burst, FOLD waits indefinitely. The grant is not revoked and other requesters are not served.
- Non-granted requesters' valid/data/last are ignored; they hold until granted.
- Backpressure: while res_valid&&!res_ready, res_* remain stable and req_ready is all 0.
- Saturation: count stops at 2**CW-1; acc keeps folding; the result stays correct.
- A zero-length burst is impossible: every burst contains at least the word carrying last.
- Reset mid-FOLD/RESP: the in-flight burst is discarded with no result. The requester must restart its burst after reset release.
- req_valid changing in the same cycle as the RESP handshake has no effect until the next IDLE cycle.

Decomposition:
- Package xor_fold_pkg:
  - state enum {IDLE, FOLD, RESP}
  - default widths
  - function for the saturating increment
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: valid vector, last_grant.
  - Outputs: any, grant_id.
  - Reusable by other shared-gate schedulers.
- XOR fold stays inline, as the accumulator register XOR word.

Test Plan:
- Reset, then req0 single word 0xA5 with last → res_valid 2 cycles later, res_data=0xA5, res_id=0, res_count=1. All outputs 0 during reset.
- req2 burst 0x0F, 0xF0, 0xFF with last on 0xFF, no bubbles → res_data=0x00, res_id=2, res_count=3, res_valid 4 cycles after first valid.
- req0, req1, req3 each hold a single word 0x11/0x22/0x33 simultaneously, res_ready=1 → results in order id 0,1,3 with data 0x11, 0x22, 0x33. req0 re-requesting after its result is served after req3.
- Backpressure:
  - Stimulus: result pending, res_ready low for 5 cycles while req1 is valid.
  - Response: res_valid held with data/id/count stable; req_ready=0; req1 is granted only after res_ready rises.
- Granted req1 burst 0x01, bubble 2 cycles, 0x03 last, while req2 is valid throughout → req2 never ready during the bubble; res_data=0x02, res_count=2.
- Saturation and reset:
  - 300-word burst of 0x01 → res_data=0x00, res_count=255.
  - rst_n low mid-FOLD → all outputs 0 immediately, no result emitted; after release, requester 0 wins again.
